// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with a four-state access sequencer
module dmem_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_sign_mask,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_sign_mask,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ADDR, ACCESS, RESP} state_t;

    state_t      state;
    logic        cap_we;
    logic        cap_port;
    logic        last_port;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_mask;
    logic        pick_p1;
    logic        idle_ok;

    // Port 1 wins when alone, or on a tie when round-robin says port 0 went last.
    always_comb begin
        pick_p1 = p1_req && (!p0_req || (RR_EN && !last_port));
        idle_ok = rst_n && (state == IDLE);
        p0_gnt  = idle_ok && p0_req && !pick_p1;
        p1_gnt  = idle_ok && pick_p1;
    end

    assign mem_addr       = cap_addr;
    assign mem_write_data = cap_wdata;
    assign mem_sign_mask  = cap_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cap_we       <= 1'b0;
            cap_port     <= 1'b0;
            last_port    <= 1'b1;
            cap_addr     <= 32'h0;
            cap_wdata    <= 32'h0;
            cap_mask     <= 4'h0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            p0_done      <= 1'b0;
            p1_done      <= 1'b0;
            p0_rdata     <= 32'h0;
            p1_rdata     <= 32'h0;
            busy         <= 1'b0;
        end else begin
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_gnt || p1_gnt) begin
                        cap_we    <= p1_gnt ? p1_we : p0_we;
                        cap_addr  <= p1_gnt ? p1_addr : p0_addr;
                        cap_wdata <= p1_gnt ? p1_wdata : p0_wdata;
                        cap_mask  <= p1_gnt ? p1_sign_mask : p0_sign_mask;
                        cap_port  <= p1_gnt;
                        last_port <= p1_gnt;
                        busy      <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    mem_memread  <= !cap_we;
                    mem_memwrite <= cap_we;
                    state        <= ACCESS;
                end
                ACCESS: begin
                    mem_memread  <= 1'b0;
                    mem_memwrite <= 1'b0;
                    state        <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (cap_port) begin
                        p1_done <= 1'b1;
                        if (!cap_we) p1_rdata <= mem_read_data;
                    end else begin
                        p0_done <= 1'b1;
                        if (!cap_we) p0_rdata <= mem_read_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with random two-port traffic
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req[2];
    logic        we[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic [3:0]  mask[2];

    logic        p0_gnt, p1_gnt, p0_done, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_write_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memread, mem_memwrite, busy;
    logic [31:0] mem_read_data = 32'h0;

    logic        fp_p0_gnt, fp_p1_gnt, fp_p0_done, fp_p1_done;
    logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_mem_addr, fp_mem_write_data;
    logic [3:0]  fp_mem_sign_mask;
    logic        fp_mem_memread, fp_mem_memwrite, fp_busy;

    dmem_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p0_sign_mask(mask[0]), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p1_sign_mask(mask[1]), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    dmem_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(1'b1), .p0_we(1'b0), .p0_addr(32'h0), .p0_wdata(32'h0),
        .p0_sign_mask(4'h0), .p0_gnt(fp_p0_gnt), .p0_done(fp_p0_done), .p0_rdata(fp_p0_rdata),
        .p1_req(1'b1), .p1_we(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0),
        .p1_sign_mask(4'h0), .p1_gnt(fp_p1_gnt), .p1_done(fp_p1_done), .p1_rdata(fp_p1_rdata),
        .mem_addr(fp_mem_addr), .mem_write_data(fp_mem_write_data),
        .mem_sign_mask(fp_mem_sign_mask), .mem_memread(fp_mem_memread),
        .mem_memwrite(fp_mem_memwrite), .mem_read_data(32'h0), .busy(fp_busy)
    );

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  mask;
        int          gcyc;
    } txn_t;

    txn_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          free_at = 0;
    int          last = 1;
    int          fp_last = -1;
    int          fp_cnt = 0;
    bit          mon_en = 0;
    bit          granted[2];
    logic [31:0] model_rdata[2];
    logic [31:0] mon_rdata[2];
    logic [31:0] mem_store[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(logic [31:0] a);
        return a ^ 32'hC3A5_0F00;
    endfunction

    // Behavioural data memory: registered read, write on the strobe edge.
    always @(posedge clk) begin
        if (mem_memwrite) mem_store[mem_addr] = mem_write_data;
        if (mem_memread) mem_read_data <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : dflt(mem_addr);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic new_cmd(int p);
        we[p]    = 1'($urandom_range(0, 1));
        addr[p]  = 32'h4000 + 32'($urandom_range(0, 7) << 2);
        wdata[p] = $urandom;
        mask[p]  = 4'($urandom_range(0, 15));
    endtask

    // Reference arbitration: one access per 4 cycles, tie goes to the port not granted last.
    task automatic tick_check();
        int win;
        txn_t e;
        #1;
        win = -1;
        if (rst_n && cyc >= free_at) begin
            if (req[0] && req[1]) win = (last == 1) ? 0 : 1;
            else if (req[0]) win = 0;
            else if (req[1]) win = 1;
        end
        chk("p0_gnt", 32'(p0_gnt), 32'(win == 0));
        chk("p1_gnt", 32'(p1_gnt), 32'(win == 1));
        granted[0] = 0;
        granted[1] = 0;
        if (win >= 0) begin
            e.port = win; e.we = we[win]; e.addr = addr[win]; e.wdata = wdata[win];
            e.mask = mask[win]; e.gcyc = cyc;
            if (!we[win])
                model_rdata[win] = ref_mem.exists(addr[win]) ? ref_mem[addr[win]] : dflt(addr[win]);
            else
                ref_mem[addr[win]] = wdata[win];
            e.rdata = model_rdata[win];
            sb.push_back(e);
            last = win;
            free_at = cyc + 4;
            granted[win] = 1;
        end
    endtask

    // mode 0: drop after grant; 1: random traffic; 2: both ports always requesting
    task automatic step(int mode);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (granted[p]) begin
                if (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0)) new_cmd(p);
                else req[p] = 1'b0;
            end else if (mode == 2 && !req[p]) begin
                req[p] = 1'b1; new_cmd(p);
            end else if (mode == 1 && !req[p]) begin
                if ($urandom_range(0, 2) == 0) begin req[p] = 1'b1; new_cmd(p); end
            end else if (mode == 1 && $urandom_range(0, 15) == 0) begin
                req[p] = 1'b0;
            end
        end
        tick_check();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_rd, exp_wr, exp_busy;
            bit exp_done[2];
            #2;
            exp_rd = 0; exp_wr = 0; exp_busy = 0; exp_done[0] = 0; exp_done[1] = 0;
            foreach (sb[i]) begin
                if (cyc >= sb[i].gcyc + 1 && cyc <= sb[i].gcyc + 3) exp_busy = 1;
                if (cyc == sb[i].gcyc + 2) begin exp_rd = !sb[i].we; exp_wr = sb[i].we; end
                if (cyc == sb[i].gcyc + 4) exp_done[sb[i].port] = 1;
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("mem_memread", 32'(mem_memread), 32'(exp_rd));
            chk("mem_memwrite", 32'(mem_memwrite), 32'(exp_wr));
            chk("p0_done", 32'(p0_done), 32'(exp_done[0]));
            chk("p1_done", 32'(p1_done), 32'(exp_done[1]));
            if (sb.size() > 0 && cyc >= sb[0].gcyc + 1 && cyc <= sb[0].gcyc + 3) begin
                chk("mem_addr", mem_addr, sb[0].addr);
                chk("mem_write_data", mem_write_data, sb[0].wdata);
                chk("mem_sign_mask", 32'(mem_sign_mask), 32'(sb[0].mask));
            end
            if (sb.size() > 0 && cyc >= sb[0].gcyc + 4) begin
                mon_rdata[sb[0].port] = sb[0].rdata;
                void'(sb.pop_front());
            end
            chk("p0_rdata", p0_rdata, mon_rdata[0]);
            chk("p1_rdata", p1_rdata, mon_rdata[1]);
            if (fp_p1_gnt) chk("fp_p1_gnt", 32'(fp_p1_gnt), 32'h0);
            if (fp_p0_gnt) begin
                if (fp_last >= 0) chk("fp_interval", 32'(cyc - fp_last), 32'd4);
                fp_last = cyc;
                fp_cnt++;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = 32'h0; wdata[p] = 32'h0; mask[p] = 4'h0;
            model_rdata[p] = 32'h0; mon_rdata[p] = 32'h0; granted[p] = 0;
        end
        req[0] = 1'b1;
        mem_store[32'h4008] = 32'hDEADBEEF;
        ref_mem[32'h4008]   = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk);
            chk("rst_p0_gnt", 32'(p0_gnt), 32'h0);
            chk("rst_p1_gnt", 32'(p1_gnt), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_strobes", 32'({mem_memread, mem_memwrite, p0_done, p1_done}), 32'h0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);
            chk("rst_fp_gnt", 32'({fp_p0_gnt, fp_p1_gnt}), 32'h0);
        end

        // Port 0 word read and port 1 byte write raised together; p0 wins the first tie.
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;
        we[0] = 1'b0; addr[0] = 32'h00004008; mask[0] = 4'b0100; wdata[0] = 32'h0;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h00004001; wdata[1] = 32'h000000A5; mask[1] = 4'b0000;
        tick_check();
        repeat (12) step(0);

        repeat (400) step(1);
        repeat (8) step(0);
        repeat (40) step(2);
        repeat (8) step(0);

        // One-cycle p0 pulse while busy must leave no trace.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h00004010;
        tick_check();
        @(negedge clk);
        req[1] = 1'b0; req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h00004014;
        tick_check();
        @(negedge clk);
        req[0] = 1'b0;
        tick_check();
        repeat (6) step(0);

        // Write to 0x2000 abandoned by reset in ACCESS, then a p1 read right after release.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h00002000; wdata[0] = 32'h12345678; mask[0] = 4'h2;
        tick_check();
        step(0);
        @(negedge clk);
        tick_check();
        #2;
        rst_n = 1'b0;
        sb.delete();
        ref_mem.delete(32'h00002000);
        model_rdata[0] = 32'h0; model_rdata[1] = 32'h0;
        mon_rdata[0] = 32'h0; mon_rdata[1] = 32'h0;
        last = 1; free_at = 0; fp_last = -1;
        #1;
        chk("abort_memwrite", 32'(mem_memwrite), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'({p0_done, p1_done}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h00004008;
        tick_check();
        repeat (10) step(0);

        @(negedge clk);
        #3;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        chk("fp_grants_seen", 32'(fp_cnt > 50), 32'h1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 = round-robin between ports, 0 = fixed priority with port 0 always winning.
REQ-002 Port clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Ports p0_req / p1_req  input  1  request from port 0 / port 1, held with its command signals until the matching gnt is sampled high.
REQ-005 Ports p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-006 Ports p0_addr / p1_addr  input  32  byte address.
REQ-007 Ports p0_wdata / p1_wdata  input  32  write data.
REQ-008 Ports p0_sign_mask / p1_sign_mask  input  4  access size/sign code, passed through unmodified to data memory.
REQ-009 Ports p0_gnt / p1_gnt  output  1  combinational grant, valid only in IDLE; command is captured on the edge where gnt is high.
REQ-010 Ports p0_done / p1_done  output  1  registered one-cycle completion pulse.
REQ-011 Ports p0_rdata / p1_rdata  output  32  registered read data for the port's last completed read.
REQ-012 Port mem_addr  output  32  address to data memory.
REQ-013 Port mem_write_data  output  32  write data to data memory.
REQ-014 Port mem_sign_mask  output  4  sign_mask to data memory.
REQ-015 Port mem_memread / mem_memwrite  output  1  memory strobes.
REQ-016 Port mem_read_data  input  32  registered read data from data memory.
REQ-017 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, ADDR, ACCESS, RESP; sequence IDLE->ADDR->ACCESS->RESP->IDLE, no other transitions except reset.
REQ-019 IDLE: if any req is high, assert the winner's gnt, capture its we/addr/wdata/sign_mask and its port id, and go to ADDR; otherwise stay in IDLE.
REQ-020 Arbitration: single req wins; with both high and RR_EN=1, winner is the port not granted last (last-granted register resets to port 1, so port 0 wins the first tie); with RR_EN=0, port 0 wins.
REQ-021 At most one gnt is high in any cycle; gnt is never high outside IDLE.
REQ-022 mem_addr, mem_write_data and mem_sign_mask always drive the captured registers, stable for ADDR, ACCESS and RESP.
REQ-023 ADDR: mem_memread = mem_memwrite = 0. This gives data memory one cycle to register the address.
REQ-024 ACCESS: exactly one of mem_memread (captured we=0) or mem_memwrite (captured we=1) is high, for exactly one cycle.
REQ-025 RESP: strobes low; on the edge leaving RESP, the owning port's done is set for one cycle.
REQ-026 On the edge leaving RESP, for a read only, the owning port's rdata loads mem_read_data; for a write, rdata is unchanged; the other port's rdata is never changed.
REQ-027 Latency: gnt in cycle T, ADDR in T+1, strobe in T+2, RESP in T+3, done in T+4; the next grant is possible in T+4; peak throughput is one access per 4 cycles.
REQ-028 A req still high in the done cycle is treated as a new request.
REQ-029 A req dropped before its gnt has no effect.
REQ-030 Requests arriving outside IDLE wait; no command is queued beyond the captured one.
REQ-031 Address and size are not checked; LED address 0x2000 is handled like any other address.

Reset
REQ-032 rst_n low asynchronously forces IDLE, clears all captured registers, the last-granted register (= port 1) and both rdata registers, and drives every output to 0 immediately.
REQ-033 Reset mid-transaction abandons it: the strobe drops at once and no done is issued, then or after reset release.
REQ-034 After rst_n rises, a request is accepted from IDLE on the first clock edge.

Verification
REQ-035 Reset: hold rst_n=0 with p0_req=1 -> all outputs 0, busy=0, no gnt.
REQ-036 Port 0 word read: addr 0x00004008, sign_mask 4'b0100, memory returns 0xDEADBEEF -> p0_gnt at T; mem_addr=0x00004008 at T+1..T+3; mem_memread only at T+2; p0_done at T+4 with p0_rdata=0xDEADBEEF.
REQ-037 Port 1 byte write: addr 0x00004001, wdata 0x000000A5, sign_mask 4'b0000 -> mem_memwrite only at T+2 with mem_write_data=0x000000A5; p1_done at T+4; p1_rdata unchanged.
REQ-038 Both reqs held continuously after reset, RR_EN=1 -> grants alternate p0, p1, p0, ... every 4 cycles; with RR_EN=0 -> p0 every time, p1 never granted.
REQ-039 Write to 0x00002000 interrupted by rst_n=0 in ACCESS -> mem_memwrite falls asynchronously, no done; after release, a new p1 read is granted in the first cycle.
REQ-040 p0_req pulsed for one cycle while busy and dropped before IDLE -> no gnt, no memory access, no done.
